// File: rtl/regfile_scoreboard.sv
// Two-read / one-write register file with write-to-read bypass and a
// per-register busy scoreboard. One index (ZERO_REG) reads as zero and is
// never written or marked busy. PendingCount is the registered popcount of busy.
module regfile_scoreboard #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = DEPTH - 1,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2,
  output logic              ReadBusy1,
  output logic              ReadBusy2,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] IssueRegister,
  input  logic              IssueValid,
  output logic [ADDR_W:0]   PendingCount
);

  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic [ADDR_W:0]  count_next;
  logic             wr_en;
  logic             issue_en;

  assign wr_en    = RegWrite && (WriteRegister != ZR);
  assign issue_en = IssueValid && (IssueRegister != ZR);

  // Scoreboard next state: issue is applied after write so a new producer wins.
  always_comb begin
    busy_next = busy;
    if (wr_en)
      busy_next[WriteRegister] = 1'b0;
    if (issue_en)
      busy_next[IssueRegister] = 1'b1;
    busy_next[ZR] = 1'b0;
  end

  // Population count of the next busy vector, registered as PendingCount.
  always_comb begin
    count_next = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      count_next = count_next + (ADDR_W + 1)'(busy_next[i]);
  end

  // Register array, busy bits and pending counter update.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      busy         <= '0;
      PendingCount <= '0;
    end else begin
      if (wr_en)
        regs[WriteRegister] <= WriteData;
      busy         <= busy_next;
      PendingCount <= count_next;
    end
  end

  // Read port 1: zero register, then same-cycle bypass, then stored state.
  always_comb begin
    ReadData1 = regs[ReadRegister1];
    ReadBusy1 = busy[ReadRegister1];
    if (ReadRegister1 == ZR) begin
      ReadData1 = '0;
      ReadBusy1 = 1'b0;
    end else if (BYPASS != 0 && !reset && RegWrite && WriteRegister == ReadRegister1) begin
      ReadData1 = WriteData;
      ReadBusy1 = 1'b0;
    end
  end

  // Read port 2: identical to port 1, independent index.
  always_comb begin
    ReadData2 = regs[ReadRegister2];
    ReadBusy2 = busy[ReadRegister2];
    if (ReadRegister2 == ZR) begin
      ReadData2 = '0;
      ReadBusy2 = 1'b0;
    end else if (BYPASS != 0 && !reset && RegWrite && WriteRegister == ReadRegister2) begin
      ReadData2 = WriteData;
      ReadBusy2 = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard at default parameters.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister, IssueRegister;
  logic [63:0] ReadData1, ReadData2, WriteData;
  logic        ReadBusy1, ReadBusy2, RegWrite, IssueValid;
  logic [5:0]  PendingCount;

  int total = 0;
  int bad   = 0;

  regfile_scoreboard #(.WIDTH(64), .DEPTH(32), .BYPASS(1)) dut (
    .clk(clk), .reset(reset),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .ReadBusy1(ReadBusy1), .ReadBusy2(ReadBusy2),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .IssueRegister(IssueRegister), .IssueValid(IssueValid),
    .PendingCount(PendingCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; RegWrite = 1'b0; IssueValid = 1'b0;
    ReadRegister1 = '0; ReadRegister2 = '0; WriteRegister = '0; IssueRegister = '0;
    WriteData = '0;
    step(); step();
    reset = 1'b0;
    #1;

    // 1: everything zero after reset
    check("rst_count", 64'(PendingCount), 64'd0);
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(31 - i);
      #1;
      check("rst_rd1", ReadData1, 64'd0);
      check("rst_rd2", ReadData2, 64'd0);
      check("rst_busy", {62'd0, ReadBusy1, ReadBusy2}, 64'd0);
    end

    // 2: bypass during the write cycle, stored value afterwards
    step();
    RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 64'hDEADBEEF_00000005;
    ReadRegister1 = 5'd3; ReadRegister2 = 5'd4;
    #1;
    check("byp_rd1", ReadData1, 64'hDEADBEEF_00000005);
    check("byp_rd2_other", ReadData2, 64'd0);
    step();
    RegWrite = 1'b0; WriteData = 64'h1234;
    #1;
    check("stored_rd1", ReadData1, 64'hDEADBEEF_00000005);

    // 3: zero register ignores write and issue
    RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = '1;
    IssueValid = 1'b1; IssueRegister = 5'd31;
    ReadRegister1 = 5'd31; ReadRegister2 = 5'd31;
    #1;
    check("zr_rd1_same", ReadData1, 64'd0);
    check("zr_busy_same", 64'(ReadBusy1), 64'd0);
    step();
    RegWrite = 1'b0; IssueValid = 1'b0;
    #1;
    check("zr_rd2", ReadData2, 64'd0);
    check("zr_busy2", 64'(ReadBusy2), 64'd0);
    check("zr_count", 64'(PendingCount), 64'd0);

    // 4: issue r5, issue r6, write r5
    IssueValid = 1'b1; IssueRegister = 5'd5; ReadRegister1 = 5'd5; ReadRegister2 = 5'd6;
    #1;
    check("iss_not_yet", 64'(ReadBusy1), 64'd0);
    step();
    IssueRegister = 5'd6;
    #1;
    check("cnt_1", 64'(PendingCount), 64'd1);
    check("r5_busy", 64'(ReadBusy1), 64'd1);
    check("r6_idle", 64'(ReadBusy2), 64'd0);
    step();
    IssueValid = 1'b0; RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 64'd55;
    #1;
    check("cnt_2", 64'(PendingCount), 64'd2);
    check("r5_byp_busy", 64'(ReadBusy1), 64'd0);
    check("r5_byp_data", ReadData1, 64'd55);
    check("r6_busy", 64'(ReadBusy2), 64'd1);
    step();
    RegWrite = 1'b0;
    #1;
    check("cnt_back_1", 64'(PendingCount), 64'd1);
    check("r5_cleared", 64'(ReadBusy1), 64'd0);
    check("r6_still", 64'(ReadBusy2), 64'd1);
    check("r5_data", ReadData1, 64'd55);

    // 5: issue and write same register on one edge -> busy wins, data stored
    IssueValid = 1'b1; IssueRegister = 5'd7;
    RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'd7;
    step();
    IssueValid = 1'b0; RegWrite = 1'b0; ReadRegister1 = 5'd7;
    #1;
    check("r7_data", ReadData1, 64'd7);
    check("r7_busy", 64'(ReadBusy1), 64'd1);
    check("cnt_r7", 64'(PendingCount), 64'd2);

    // 6: fill scoreboard, then reset with a concurrent write
    for (int i = 1; i <= 30; i++) begin
      IssueValid = 1'b1; IssueRegister = 5'(i);
      step();
    end
    IssueValid = 1'b0;
    #1;
    check("cnt_full", 64'(PendingCount), 64'd30);
    reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd2; WriteData = 64'd9;
    IssueValid = 1'b1; IssueRegister = 5'd4;
    ReadRegister1 = 5'd2; ReadRegister2 = 5'd3;
    #1;
    check("rst_no_byp", ReadData1, 64'd0);
    check("rst_busy_stored", 64'(ReadBusy1), 64'd1);
    step();
    reset = 1'b0; RegWrite = 1'b0; IssueValid = 1'b0;
    #1;
    check("cnt_after_rst", 64'(PendingCount), 64'd0);
    check("r2_after_rst", ReadData1, 64'd0);
    check("r2_busy_rst", 64'(ReadBusy1), 64'd0);
    check("r3_after_rst", ReadData2, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
